// File: rtl/imem_arbiter.sv
// imem_arbiter: two-port arbiter and storage for the shared instruction memory.
// The host loader port (read/write) and the CPU fetch port (read-only) share one
// single-port byte array. Grants are combinational. Read data is registered.
// Optional feature: define IMEM_ARB_RR_EN for round-robin arbitration.
// In the default build the host always wins contention.
module imem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              prog_lock,
   output logic              busy,
   output logic [CNT_W-1:0]  cpu_stall_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              last_host;
   logic              cpu_eff;
   logic              host_wins;
   logic              host_rvalid_q;
   logic              cpu_rvalid_q;
   logic              busy_q;

   // Arbitration: mask the CPU request with prog_lock, then pick at most one winner.
   always_comb begin
      cpu_eff = cpu_req & ~prog_lock;
`ifdef IMEM_ARB_RR_EN
      // The port that did not win last time wins contention now.
      host_wins = ~last_host;
`else
      // Fixed priority. The pointer is still tracked but cannot change the outcome.
      host_wins = last_host | 1'b1;
`endif
      host_gnt = ~rst & host_req & (~cpu_eff | host_wins);
      cpu_gnt  = ~rst & cpu_eff & (~host_req | ~host_wins);
   end

   // A pending result is squashed while reset is asserted.
   assign host_rvalid = host_rvalid_q & ~rst;
   assign cpu_rvalid  = cpu_rvalid_q & ~rst;
   assign busy        = busy_q & ~rst;

   // Memory write port. Contents are not reset, and the grant is already gated by rst.
   always_ff @(posedge clk) begin
      if (host_gnt && host_we) mem[host_addr] <= host_wdata;
   end

   // Registered read results, the priority pointer and the CPU stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         host_rvalid_q <= 1'b0;
         cpu_rvalid_q  <= 1'b0;
         busy_q        <= 1'b0;
         host_rdata    <= '0;
         cpu_rdata     <= '0;
         last_host     <= 1'b0;
         cpu_stall_cnt <= '0;
      end else begin
         host_rvalid_q <= host_gnt & ~host_we;
         cpu_rvalid_q  <= cpu_gnt;
         busy_q        <= (host_gnt & ~host_we) | cpu_gnt;
         if (host_gnt && !host_we) host_rdata <= mem[host_addr];
         if (cpu_gnt) cpu_rdata <= mem[cpu_addr];
         if (host_gnt) last_host <= 1'b1;
         else if (cpu_gnt) last_host <= 1'b0;
         if (cpu_req && !cpu_gnt && (cpu_stall_cnt != '1))
            cpu_stall_cnt <= cpu_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter. Expected read data is queued when a grant is seen and
// popped when the matching rvalid appears, with the arrival cycle checked too.
module tb_imem_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       host_req, host_we;
   logic [4:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_gnt, host_rvalid;
   logic [7:0] host_rdata;
   logic       cpu_req;
   logic [4:0] cpu_addr;
   logic       cpu_gnt, cpu_rvalid;
   logic [7:0] cpu_rdata;
   logic       prog_lock;
   logic       busy;
   logic [7:0] cpu_stall_cnt;

   imem_arbiter dut (
      .clk(clk), .rst(rst),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .prog_lock(prog_lock), .busy(busy), .cpu_stall_cnt(cpu_stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      int         c;
   } exp_t;

   exp_t       hq[$];
   exp_t       cq[$];
   logic [7:0] model [32];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Drive point: 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      host_req = 1'b0; cpu_req = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // Scoreboard side: every rvalid must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (host_rvalid === 1'b1) begin
         n_cmp++;
         if (hq.size() == 0) begin
            n_err++;
            $display("FAIL host_rvalid_unexpected: got pulse at cycle %0d, required none", cyc);
         end else begin
            e = hq.pop_front();
            if (host_rdata !== e.d || cyc != e.c) begin
               n_err++;
               $display("FAIL host_rdata: got %h at cycle %0d, required %h at cycle %0d",
                        host_rdata, cyc, e.d, e.c);
            end
         end
      end
      if (cpu_rvalid === 1'b1) begin
         n_cmp++;
         if (cq.size() == 0) begin
            n_err++;
            $display("FAIL cpu_rvalid_unexpected: got pulse at cycle %0d, required none", cyc);
         end else begin
            e = cq.pop_front();
            if (cpu_rdata !== e.d || cyc != e.c) begin
               n_err++;
               $display("FAIL cpu_rdata: got %h at cycle %0d, required %h at cycle %0d",
                        cpu_rdata, cyc, e.d, e.c);
            end
         end
      end
   end

   task automatic host_write(input logic [4:0] a, input logic [7:0] d);
      host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      #1;
      n_cmp++;
      if (host_gnt !== 1'b1) begin
         n_err++;
         $display("FAIL host_write_gnt: got %b, required 1 (addr %0d)", host_gnt, a);
      end
      model[a] = d;
      step();
      host_req = 1'b0; host_we = 1'b0;
   endtask

   task automatic cpu_read(input logic [4:0] a);
      exp_t e;
      cpu_req = 1'b1; cpu_addr = a;
      #1;
      n_cmp++;
      if (cpu_gnt !== 1'b1) begin
         n_err++;
         $display("FAIL cpu_read_gnt: got %b, required 1 (addr %0d)", cpu_gnt, a);
      end
      e.d = model[a]; e.c = cyc + 1;
      cq.push_back(e);
      step();
      cpu_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 5'd0; cpu_req = 1'b1;
      #1;
      n_cmp++;
      if (host_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin
         n_err++;
         $display("FAIL reset_gnt: got host %b cpu %b, required 0 0", host_gnt, cpu_gnt);
      end
      step();
      host_req = 1'b0; cpu_req = 1'b0;
      step();
      n_cmp++;
      if (host_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || host_rdata !== 8'h00 ||
          cpu_rdata !== 8'h00 || busy !== 1'b0 || cpu_stall_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL reset_state: got rv %b/%b rd %h/%h busy %b cnt %0d, required all 0",
                  host_rvalid, cpu_rvalid, host_rdata, cpu_rdata, busy, cpu_stall_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_load_fetch();
      host_write(5'd0, 8'h01);
      host_write(5'd1, 8'h2A);
      host_write(5'd2, 8'h0A);
      host_write(5'd3, 8'h33);
      cpu_read(5'd0);
      cpu_read(5'd1);
      cpu_read(5'd2);
      idle(2);
   endtask

   task automatic test_raw();
      host_write(5'd5, 8'h77);
      cpu_read(5'd5);
      idle(2);
   endtask

   task automatic test_contention();
      exp_t e;
      int   hg = 0;
      int   cg = 0;
      logic want_host;
      do_reset();
      host_req = 1'b1; host_we = 1'b0; host_addr = 5'd1;
      cpu_req = 1'b1; cpu_addr = 5'd2;
      for (int i = 0; i < 6; i++) begin
         #1;
`ifdef IMEM_ARB_RR_EN
         want_host = (i % 2 == 0);
`else
         want_host = 1'b1;
`endif
         n_cmp++;
         if (host_gnt !== want_host || cpu_gnt !== !want_host) begin
            n_err++;
            $display("FAIL contention_gnt[%0d]: got host %b cpu %b, required host %b cpu %b",
                     i, host_gnt, cpu_gnt, want_host, !want_host);
         end
         if (host_gnt === 1'b1) begin
            hg++; e.d = model[1]; e.c = cyc + 1; hq.push_back(e);
         end
         if (cpu_gnt === 1'b1) begin
            cg++; e.d = model[2]; e.c = cyc + 1; cq.push_back(e);
         end
         step();
      end
      host_req = 1'b0; cpu_req = 1'b0;
      #1;
      n_cmp++;
`ifdef IMEM_ARB_RR_EN
      if (hg != 3 || cg != 3 || cpu_stall_cnt !== 8'd3) begin
         n_err++;
         $display("FAIL contention_totals: got %0d/%0d grants cnt %0d, required 3/3 cnt 3",
                  hg, cg, cpu_stall_cnt);
      end
`else
      if (hg != 6 || cg != 0 || cpu_stall_cnt !== 8'd6) begin
         n_err++;
         $display("FAIL contention_totals: got %0d/%0d grants cnt %0d, required 6/0 cnt 6",
                  hg, cg, cpu_stall_cnt);
      end
`endif
      idle(2);
   endtask

   task automatic test_prog_lock();
      exp_t e;
      int   bad = 0;
      do_reset();
      prog_lock = 1'b1; cpu_req = 1'b1; cpu_addr = 5'd1;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (cpu_gnt !== 1'b0) bad++;
         if (i == 255) begin
            n_cmp++;
            if (cpu_stall_cnt !== 8'd255) begin
               n_err++;
               $display("FAIL stall_cnt_reach: got %0d, required 255", cpu_stall_cnt);
            end
         end
         step();
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL lock_gnt: got %0d locked grants, required 0", bad);
      end
      n_cmp++;
      if (cpu_stall_cnt !== 8'd255) begin
         n_err++;
         $display("FAIL stall_cnt_sat: got %0d, required 255", cpu_stall_cnt);
      end
      prog_lock = 1'b0;
      #1;
      n_cmp++;
      if (cpu_gnt !== 1'b1) begin
         n_err++;
         $display("FAIL unlock_gnt: got %b, required 1", cpu_gnt);
      end
      e.d = model[1]; e.c = cyc + 1; cq.push_back(e);
      step();
      // Locking with a read outstanding must not cancel its result.
      prog_lock = 1'b1; cpu_req = 1'b0;
      idle(2);
      prog_lock = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      host_req = 1'b1; host_we = 1'b0; host_addr = 5'd3;
      #1;
      n_cmp++;
      if (host_gnt !== 1'b1) begin
         n_err++;
         $display("FAIL mid_read_gnt: got %b, required 1", host_gnt);
      end
      step();
      rst = 1'b1; host_req = 1'b1; cpu_req = 1'b1; cpu_addr = 5'd0;
      #1;
      n_cmp++;
      if (host_rvalid !== 1'b0 || busy !== 1'b0 || host_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: got rv %b busy %b gnt %b/%b, required 0 0 0/0",
                  host_rvalid, busy, host_gnt, cpu_gnt);
      end
      step();
      host_req = 1'b0; cpu_req = 1'b0; rst = 1'b0;
      #1;
      n_cmp++;
      if (host_rvalid !== 1'b0 || busy !== 1'b0 || cpu_stall_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL post_reset: got rv %b busy %b cnt %0d, required 0 0 0",
                  host_rvalid, busy, cpu_stall_cnt);
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      host_req = 1'b1; host_we = 1'b0; host_addr = 5'd1;
      #1;
      n_cmp++;
      if (host_gnt !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_host_gnt: got %b, required 1", host_gnt);
      end
      e.d = model[1]; e.c = cyc + 1; hq.push_back(e);
      step();
      host_req = 1'b0; cpu_req = 1'b1; cpu_addr = 5'd2;
      #1;
      n_cmp++;
      if (cpu_gnt !== 1'b1 || host_rvalid !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_cycle1: got gnt %b hrv %b busy %b, required 1 1 1",
                  cpu_gnt, host_rvalid, busy);
      end
      e.d = model[2]; e.c = cyc + 1; cq.push_back(e);
      step();
      cpu_req = 1'b0;
      #1;
      n_cmp++;
      if (cpu_rvalid !== 1'b1 || host_rvalid !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_cycle2: got crv %b hrv %b busy %b, required 1 0 1",
                  cpu_rvalid, host_rvalid, busy);
      end
      step();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle_busy: got %b, required 0", busy);
      end
      idle(1);
   endtask

   initial begin
      rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      cpu_req = 1'b0; cpu_addr = '0; prog_lock = 1'b0;
      #1;
      test_reset();
      test_load_fetch();
      test_raw();
      test_contention();
      test_prog_lock();
      test_reset_mid();
      test_back_to_back();
      n_cmp++;
      if (hq.size() != 0 || cq.size() != 0) begin
         n_err++;
         $display("FAIL missing_rvalid: got %0d host / %0d cpu outstanding, required 0 / 0",
                  hq.size(), cq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
